// File: rtl/useq_fifo_ctrl.sv
// useq_fifo_ctrl: host-side sequencer for the useq core mailbox FIFO port.
//
// A ready/valid byte stream is pushed into the core with its two-step protocol:
// the byte is presented on i_port for one cycle, then write_fifo is pulsed.
// The core FIFO is drained via read_fifo/o_port into a registered ready/valid
// output. Push and pop are arbitrated round-robin, and every strobe is followed
// by RUN_GAP strobe-free cycles so the core gets time to run between stalls.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   ext_i_port       application value for core i_port when not pushing
//   u_i_port         drives core i_port
//   u_read_fifo      core read_fifo strobe
//   u_write_fifo     core write_fifo strobe
//   u_fifo_empty     core fifo_empty
//   u_o_port         core o_port
//   s_valid/s_data   push byte in; s_ready pulses once when it is written
//   pop_en           allows draining of the core FIFO
//   m_valid/m_data   popped byte out; m_ready accepts it
//   cnt              controller's view of the core FIFO occupancy
module useq_fifo_ctrl #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RUN_GAP    = 2,
  localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    ext_i_port,
  output logic [7:0]    u_i_port,
  output logic          u_read_fifo,
  output logic          u_write_fifo,
  input  logic          u_fifo_empty,
  input  logic [7:0]    u_o_port,
  input  logic          s_valid,
  input  logic [7:0]    s_data,
  output logic          s_ready,
  input  logic          pop_en,
  output logic          m_valid,
  output logic [7:0]    m_data,
  input  logic          m_ready,
  output logic [CW-1:0] cnt
);

  // The core holds at most FIFO_DEPTH-1 entries.
  localparam logic [CW-1:0] CntMax = CW'(FIFO_DEPTH - 1);

  localparam int unsigned   GW      = (RUN_GAP > 1) ? $clog2(RUN_GAP) : 1;
  localparam logic [GW-1:0] GapLast = GW'((RUN_GAP > 0) ? (RUN_GAP - 1) : 0);

  typedef enum logic [2:0] {
    StIdle,
    StPushLat,
    StPushWr,
    StPopRd,
    StPopCap,
    StGap
  } state_e;

  state_e        state_q, state_d, after_strobe;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          last_pop_q, last_pop_d;  // 1: last tie was granted to pop
  logic          m_valid_q, m_valid_d;
  logic [7:0]    m_data_q, m_data_d;
  logic          push_req, pop_req;

  assign push_req = s_valid && (cnt_q != CntMax);
  assign pop_req  = pop_en && !m_valid_q && !u_fifo_empty && (cnt_q != '0);

  // With no run gap the sequencer returns straight to idle after a strobe.
  assign after_strobe = (RUN_GAP == 0) ? StIdle : StGap;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    last_pop_d = last_pop_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;

    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        // The core program may clear the FIFO behind our back; trust the flag.
        if (u_fifo_empty) begin
          cnt_d = '0;
        end
        if (push_req && pop_req) begin
          if (last_pop_q) begin
            state_d    = StPushLat;
            last_pop_d = 1'b0;
          end else begin
            state_d    = StPopRd;
            last_pop_d = 1'b1;
          end
        end else if (push_req) begin
          state_d = StPushLat;
        end else if (pop_req) begin
          state_d = StPopRd;
        end
      end
      StPushLat: state_d = StPushWr;
      StPushWr: begin
        if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
        state_d = after_strobe;
      end
      StPopRd: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end
        state_d = StPopCap;
      end
      StPopCap: begin
        // o_port carries the popped byte one cycle after read_fifo.
        m_data_d  = u_o_port;
        m_valid_d = 1'b1;
        state_d   = after_strobe;
      end
      StGap: begin
        if (gap_q == GapLast) begin
          gap_d   = '0;
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      gap_q      <= '0;
      last_pop_q <= 1'b1;  // push wins the first tie
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      last_pop_q <= last_pop_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
    end
  end

  // Strobes come from the state register only, so reset clears them at once.
  assign u_write_fifo = (state_q == StPushWr);
  assign s_ready      = (state_q == StPushWr);
  assign u_read_fifo  = (state_q == StPopRd);
  assign u_i_port     = ((state_q == StPushLat) || (state_q == StPushWr)) ? s_data : ext_i_port;
  assign m_valid      = m_valid_q;
  assign m_data       = m_data_q;
  assign cnt          = cnt_q;

endmodule
